// File: rtl/dest_hazard_unit.sv
// Destination shadow pipeline (EX/MEM/WB) with load-use stall and EX operand forwarding.
// Optional feature macro: FWD_EN (defined: forwarding; undefined: stall until producer reaches WB).
module dest_hazard_unit #(
  parameter int AW        = 5,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          ID_Valid,
  input  logic [AW-1:0] ID_Rs,
  input  logic [AW-1:0] ID_Rt,
  input  logic          ID_UsesRs,
  input  logic          ID_UsesRt,
  input  logic [AW-1:0] ID_Dest,
  input  logic          ID_RegWrite,
  input  logic          ID_MemRead,
  input  logic          Flush,
  output logic          Stall,
  output logic [1:0]    FwdA,
  output logic [1:0]    FwdB,
  output logic [AW-1:0] WB_Dest,
  output logic          WB_Write
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] dest;
    logic          wr;
    logic          ld;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } stage_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  stage_t id_rec;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;

  logic dest_is_zero;
  logic hit_ex;
  logic hit_mem;

  // Register 0 is hard-wired, so a write to it is dropped at capture time.
  always_comb begin
    dest_is_zero = (ID_Dest == '0);
    id_rec       = '0;
    id_rec.v     = ID_Valid;
    id_rec.dest  = ID_Dest;
    id_rec.wr    = ID_RegWrite & ID_Valid & ~(ZERO_SKIP & dest_is_zero);
    id_rec.ld    = ID_MemRead & ID_Valid;
    id_rec.rs    = ID_Rs;
    id_rec.rt    = ID_Rt;
  end

  always_comb begin
    hit_ex  = (ID_UsesRs & (ID_Rs == ex_q.dest))  | (ID_UsesRt & (ID_Rt == ex_q.dest));
    hit_mem = (ID_UsesRs & (ID_Rs == mem_q.dest)) | (ID_UsesRt & (ID_Rt == mem_q.dest));
  end

`ifdef FWD_EN
  function automatic logic [1:0] fwd_sel(input stage_t mem_s, input stage_t wb_s,
                                         input logic [AW-1:0] src);
    logic src_ok;
    src_ok = ~(ZERO_SKIP & (src == '0));
    if (src_ok & mem_s.wr & (mem_s.dest == src))
      return SEL_MEM;
    else if (src_ok & wb_s.wr & (wb_s.dest == src))
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  // Only a load in EX cannot be forwarded in time; everything else bypasses.
  always_comb begin
    Stall = ~Flush & ID_Valid & ex_q.v & ex_q.ld & ex_q.wr & hit_ex;
    FwdA  = fwd_sel(mem_q, wb_q, ex_q.rs);
    FwdB  = fwd_sel(mem_q, wb_q, ex_q.rt);
  end
`else
  // Without bypass paths, any producer still in EX or MEM blocks decode.
  always_comb begin
    Stall = ~Flush & ID_Valid &
            ((ex_q.v & ex_q.wr & hit_ex) | (mem_q.v & mem_q.wr & hit_mem));
    FwdA  = SEL_RF;
    FwdB  = SEL_RF;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (Flush || Stall)
        ex_q <= '0;
      else
        ex_q <= id_rec;
    end
  end

  assign WB_Dest  = wb_q.dest;
  assign WB_Write = wb_q.wr;

  // Fields carried for completeness but not consumed in every build.
  logic unused_bits;
  assign unused_bits = ^{wb_q.v, wb_q.ld, wb_q.rs, wb_q.rt, mem_q.v, mem_q.ld,
                         mem_q.rs, mem_q.rt, ex_q.ld, ex_q.rs, ex_q.rt,
                         SEL_MEM, SEL_WB, SEL_RF, hit_mem};

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Directed bench for dest_hazard_unit: reset, load-use, forwarding, register 0 and flush.
module tb_dest_hazard_unit;
  localparam int AW = 5;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          ID_Valid;
  logic [AW-1:0] ID_Rs;
  logic [AW-1:0] ID_Rt;
  logic          ID_UsesRs;
  logic          ID_UsesRt;
  logic [AW-1:0] ID_Dest;
  logic          ID_RegWrite;
  logic          ID_MemRead;
  logic          Flush;
  logic          Stall;
  logic [1:0]    FwdA;
  logic [1:0]    FwdB;
  logic [AW-1:0] WB_Dest;
  logic          WB_Write;

  int errors = 0;
  int checks = 0;
  int n_stall;

  dest_hazard_unit #(.AW(AW), .ZERO_SKIP(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dest(ID_Dest),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .Flush(Flush),
    .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB), .WB_Dest(WB_Dest), .WB_Write(WB_Write)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic [AW-1:0] dest,
                        input logic rw, input logic mr);
    ID_Valid    = v;
    ID_Rs       = rs;
    ID_Rt       = rt;
    ID_UsesRs   = urs;
    ID_UsesRt   = urt;
    ID_Dest     = dest;
    ID_RegWrite = rw;
    ID_MemRead  = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    Flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
    tick();
  endtask

  // Holds the current decode inputs and counts stalled cycles, bounded.
  task automatic count_stalls(output int n);
    n = 0;
    #1;
    while (Stall === 1'b1 && n < 6) begin
      n++;
      tick();
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("reset_stall", {31'b0, Stall}, 32'd0);
    chk("reset_fwda", {30'b0, FwdA}, 32'd0);
    chk("reset_fwdb", {30'b0, FwdB}, 32'd0);
    chk("reset_wb_write", {31'b0, WB_Write}, 32'd0);
    chk("reset_wb_dest", {27'b0, WB_Dest}, 32'd0);
    Rst_n = 1'b1;
    tick();

    // Fill the pipe, then pull reset mid-cycle with valid entries inside.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk("fill_wb_write", {31'b0, WB_Write}, 32'd1);
    chk("fill_wb_dest", {27'b0, WB_Dest}, 32'd3);
    set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    #1;
    chk("mem_raw_stall", {31'b0, Stall}, FWD ? 32'd0 : 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_wb_write", {31'b0, WB_Write}, 32'd0);
    chk("async_rst_wb_dest", {27'b0, WB_Dest}, 32'd0);
    chk("async_rst_stall", {31'b0, Stall}, 32'd0);
    idle();
    tick();
    Rst_n = 1'b1;
    tick();

    // First valid instruction after release reaches WB three clocks later.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    idle();
    chk("lat_clk1_wb_write", {31'b0, WB_Write}, 32'd0);
    tick();
    chk("lat_clk2_wb_write", {31'b0, WB_Write}, 32'd0);
    tick();
    chk("lat_clk3_wb_write", {31'b0, WB_Write}, 32'd1);
    chk("lat_clk3_wb_dest", {27'b0, WB_Dest}, 32'd7);
    drain();

    // lw $8 ; add $9,$8,$8
    set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    count_stalls(n_stall);
    chk("load_use_stall_cycles", n_stall, FWD ? 32'd1 : 32'd2);
    tick();
    idle();
    #1;
    chk("load_use_fwda", {30'b0, FwdA}, FWD ? 32'd1 : 32'd0);
    chk("load_use_fwdb", {30'b0, FwdB}, FWD ? 32'd1 : 32'd0);
    chk("load_use_wb_write", {31'b0, WB_Write}, FWD ? 32'd1 : 32'd0);
    chk("load_use_wb_dest", {27'b0, WB_Dest}, FWD ? 32'd8 : 32'd0);
    drain();

    // add $5 ; sub $6,$5,$7
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    count_stalls(n_stall);
    chk("alu_use_stall_cycles", n_stall, FWD ? 32'd0 : 32'd2);
    tick();
    idle();
    #1;
    chk("alu_use_fwda", {30'b0, FwdA}, FWD ? 32'd2 : 32'd0);
    chk("alu_use_fwdb", {30'b0, FwdB}, 32'd0);
    drain();

    // Two writers of $4 back to back, then a reader: MEM must win.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    count_stalls(n_stall);
    chk("double_write_stall_cycles", n_stall, FWD ? 32'd0 : 32'd2);
    tick();
    idle();
    #1;
    chk("double_write_fwda", {30'b0, FwdA}, FWD ? 32'd2 : 32'd0);
    chk("double_write_fwdb", {30'b0, FwdB}, FWD ? 32'd2 : 32'd0);
    drain();

    // lw $0 ; reader of $0
    set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    count_stalls(n_stall);
    chk("r0_stall_cycles", n_stall, 32'd0);
    tick();
    idle();
    #1;
    chk("r0_fwda", {30'b0, FwdA}, 32'd0);
    chk("r0_fwdb", {30'b0, FwdB}, 32'd0);
    tick();
    chk("r0_wb_write", {31'b0, WB_Write}, 32'd0);
    drain();

    // Load-use hit coinciding with a flush: no stall, squashed add never writes.
    set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    Flush = 1'b1;
    #1;
    chk("flush_stall", {31'b0, Stall}, 32'd0);
    tick();
    idle();
    tick();
    chk("flush_lw_wb_write", {31'b0, WB_Write}, 32'd1);
    chk("flush_lw_wb_dest", {27'b0, WB_Dest}, 32'd8);
    tick();
    chk("flush_bubble_wb_write", {31'b0, WB_Write}, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
